// File: rtl/ofifo_pkg.sv
// Shared constants and helpers for the output-side column FIFO collector.
package ofifo_pkg;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 64;

    // One extra pointer bit separates full from empty.
    function automatic int ptr_w(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/ofifo_col_fifo.sv
// One column of the collector: a bw-wide first-word-fall-through FIFO.
module ofifo_col_fifo
    import ofifo_pkg::*;
#(
    parameter int bw    = BW,
    parameter int depth = DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [bw-1:0] in,
    output logic [bw-1:0] out,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_err_wr
);

    localparam int AW = $clog2(depth);
    localparam int PW = ptr_w(depth);

    logic [bw-1:0] r_mem [depth];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          w_push;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push   = wr & ~o_full;
    assign o_err_wr = wr & o_full;
    assign out      = r_mem[r_rptr[AW-1:0]];

    // Storage is not reset; only the pointers define what is held.
    always_ff @(posedge clk) begin
        if (w_push && !reset)
            r_mem[r_wptr[AW-1:0]] <= in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (rd)
                r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/ofifo_collector.sv
// Collects skewed per-column MAC outputs and releases them as whole row vectors.
module ofifo_collector
    import ofifo_pkg::*;
#(
    parameter int col   = COL,
    parameter int bw    = BW,
    parameter int depth = DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col*bw-1:0] in,
    input  logic [col-1:0]    wr,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_err
);

    logic [col-1:0]    w_empty;
    logic [col-1:0]    w_full;
    logic [col-1:0]    w_err_wr;
    logic [col*bw-1:0] w_head;
    logic              w_pop;
    logic              r_err;

    // Every column pops together, and only when all hold data.
    assign w_pop = rd & o_valid;

    for (genvar gi = 0; gi < col; gi++) begin : g_col
        ofifo_col_fifo #(
            .bw    (bw),
            .depth (depth)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .wr       (wr[gi]),
            .rd       (w_pop),
            .in       (in[gi*bw +: bw]),
            .out      (w_head[gi*bw +: bw]),
            .o_empty  (w_empty[gi]),
            .o_full   (w_full[gi]),
            .o_err_wr (w_err_wr[gi])
        );
    end

    assign o_valid = &(~w_empty);
    assign o_full  = |w_full;
    assign o_ready = ~o_full;
    assign out     = o_valid ? w_head : '0;
    assign o_err   = r_err;

    always_ff @(posedge clk) begin
        if (reset)
            r_err <= 1'b0;
        else if ((rd && !o_valid) || (|w_err_wr))
            r_err <= 1'b1;
    end

endmodule

// File: tb/tb_ofifo_collector.sv
// Directed self-checking bench for ofifo_collector.
module tb_ofifo_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] in;
    logic [7:0]   wr;
    logic         rd;
    logic [127:0] out;
    logic         o_valid, o_full, o_ready, o_err;

    int n_cmp = 0;
    int n_bad = 0;

    ofifo_collector #(.col(8), .bw(16), .depth(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = '0;
        rd = 1'b0;
        in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    function automatic logic [127:0] vec(input int n);
        logic [127:0] v;
        for (int c = 0; c < 8; c++)
            v[c*16 +: 16] = 16'(n * 8 + c);
        return v;
    endfunction

    logic [127:0] q[$];
    logic [127:0] exp_v;
    int wn, rn;

    initial begin
        reset = 1'b1;
        idle();
        do_reset();
        chk("rst_valid", 128'(o_valid), 128'd0);
        chk("rst_out", out, 128'd0);
        chk("rst_full", 128'(o_full), 128'd0);
        chk("rst_ready", 128'(o_ready), 128'd1);
        chk("rst_err", 128'(o_err), 128'd0);

        // Skewed fill, one column per cycle
        exp_v = '0;
        for (int k = 0; k < 8; k++) begin
            chk("skew_valid_lo", 128'(o_valid), 128'd0);
            in = '0;
            in[k*16 +: 16] = 16'h0100 + 16'(k);
            exp_v[k*16 +: 16] = 16'h0100 + 16'(k);
            wr = 8'(1 << k);
            cyc();
        end
        idle();
        chk("skew_valid_hi", 128'(o_valid), 128'd1);
        chk("skew_out", out, exp_v);
        rd = 1'b1;
        cyc();
        idle();
        chk("skew_pop_valid", 128'(o_valid), 128'd0);
        chk("skew_pop_out", out, 128'd0);
        chk("skew_err", 128'(o_err), 128'd0);

        // Overflow on column 3
        for (int i = 0; i < 64; i++) begin
            in = '0;
            in[48 +: 16] = 16'(i);
            wr = 8'h08;
            cyc();
        end
        idle();
        chk("ovf_full", 128'(o_full), 128'd1);
        chk("ovf_ready", 128'(o_ready), 128'd0);
        chk("ovf_err_pre", 128'(o_err), 128'd0);
        in[48 +: 16] = 16'hFFFF;
        wr = 8'h08;
        cyc();
        idle();
        chk("ovf_err", 128'(o_err), 128'd1);
        for (int i = 0; i < 64; i++) begin
            in = vec(1000 + i);
            wr = 8'hF7;
            cyc();
        end
        idle();
        for (int i = 0; i < 64; i++) begin
            exp_v = vec(1000 + i);
            exp_v[48 +: 16] = 16'(i);
            chk("ovf_read", out, exp_v);
            rd = 1'b1;
            cyc();
        end
        idle();
        chk("ovf_drained", 128'(o_valid), 128'd0);
        chk("ovf_not_full", 128'(o_full), 128'd0);

        // Underflow
        do_reset();
        chk("udf_err_clr", 128'(o_err), 128'd0);
        in = '0;
        in[15:0] = 16'h00AA;
        wr = 8'h01;
        cyc();
        idle();
        rd = 1'b1;
        cyc();
        idle();
        chk("udf_err", 128'(o_err), 128'd1);
        chk("udf_valid", 128'(o_valid), 128'd0);
        for (int c = 1; c < 8; c++)
            in[c*16 +: 16] = 16'h0B00 + 16'(c);
        wr = 8'hFE;
        exp_v = in;
        exp_v[15:0] = 16'h00AA;
        cyc();
        idle();
        chk("udf_valid_hi", 128'(o_valid), 128'd1);
        chk("udf_data", out, exp_v);

        // Streaming with push and pop in the same cycle
        do_reset();
        wn = 0;
        rn = 0;
        for (int t = 0; t < 400 && rn < 200; t++) begin
            wr = (wn < 200) ? 8'hFF : 8'h00;
            in = vec(wn);
            rd = o_valid;
            if (o_valid) begin
                chk("stream", out, q.size() > 0 ? q[0] : 128'hx);
                if (q.size() > 0) void'(q.pop_front());
                rn++;
            end
            if (wn < 200) begin
                q.push_back(vec(wn));
                wn++;
            end
            cyc();
        end
        idle();
        chk("stream_count", 128'(rn), 128'd200);
        chk("stream_err", 128'(o_err), 128'd0);
        chk("stream_empty", 128'(o_valid), 128'd0);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) begin
            in = vec(300 + i);
            wr = 8'hFF;
            cyc();
        end
        idle();
        chk("mid_valid_pre", 128'(o_valid), 128'd1);
        reset = 1'b1;
        rd = 1'b1;
        wr = 8'hFF;
        in = vec(400);
        cyc();
        reset = 1'b0;
        idle();
        chk("mid_valid", 128'(o_valid), 128'd0);
        chk("mid_out", out, 128'd0);
        chk("mid_err", 128'(o_err), 128'd0);
        in = vec(500);
        wr = 8'hFF;
        cyc();
        idle();
        chk("mid_wr_valid", 128'(o_valid), 128'd1);
        chk("mid_wr_out", out, vec(500));
        rd = 1'b1;
        cyc();
        idle();
        chk("mid_rd_valid", 128'(o_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
